// File: rtl/stream_hub.sv
// stream_hub: round-robin merge of CHANNELS strobe/ack input streams into one
// DEPTH-word output FIFO, with a sticky aggregated exception flag.
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   input_in        channel k data in bits [k*WIDTH +: WIDTH]
//   input_in_stb    per-channel data valid
//   input_in_ack    per-channel acknowledge (combinational, one-hot or zero)
//   output_out      FIFO head data (0 when empty)
//   output_out_stb  FIFO non-empty
//   output_out_ack  sink acknowledge; pop when stb and ack both high
//   exception_in    per-channel exception flags
//   exception       sticky exception, held until reset
//   exception_src   lowest channel index flagged on the first exception edge
//   output_out_tag  source channel of the head word (STREAM_HUB_TAG_EN only)
//
// Build option: define STREAM_HUB_TAG_EN to store and emit a per-word source tag.

module stream_hub #(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned DEPTH    = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [CHANNELS*WIDTH-1:0]     input_in,
   input  logic [CHANNELS-1:0]           input_in_stb,
   output logic [CHANNELS-1:0]           input_in_ack,
   output logic [WIDTH-1:0]              output_out,
   output logic                          output_out_stb,
   input  logic                          output_out_ack,
   input  logic [CHANNELS-1:0]           exception_in,
   output logic                          exception,
   output logic [$clog2(CHANNELS)-1:0]   exception_src
`ifdef STREAM_HUB_TAG_EN
   ,
   output logic [$clog2(CHANNELS)-1:0]   output_out_tag
`endif
);

   localparam int unsigned SRC_W = $clog2(CHANNELS);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
`ifdef STREAM_HUB_TAG_EN
   localparam int unsigned TAG_W = SRC_W;
`else
   localparam int unsigned TAG_W = 0;
`endif
   localparam int unsigned ENTRY_W = WIDTH + TAG_W;

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic [SRC_W-1:0]   last_grant;

   logic               grant_found;
   logic [SRC_W-1:0]   grant_idx;
   int unsigned        cand;
   logic [SRC_W-1:0]   cand_idx;
   logic               push;
   logic               pop;
   logic               not_empty;
   logic [WIDTH-1:0]   sel_data;
   logic [ENTRY_W-1:0] wr_entry;
   logic [ENTRY_W-1:0] head_entry;

   logic               exc_found;
   logic [SRC_W-1:0]   exc_idx;
   int unsigned        exc_i;

   // Round-robin search starting one past the last accepted channel.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      cand_idx    = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         cand     = (32'(last_grant) + 32'd1 + i) % CHANNELS;
         cand_idx = SRC_W'(cand);
         if (!grant_found && input_in_stb[cand_idx]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx;
         end
      end
   end

   // Push is refused whenever full, even if the sink pops in the same cycle.
   always_comb begin
      not_empty      = (count != '0);
      push           = grant_found && (count < CNT_W'(DEPTH)) && !rst;
      pop            = not_empty && output_out_ack && !rst;
      input_in_ack   = push ? (CHANNELS'(1) << grant_idx) : '0;
      output_out_stb = not_empty && !rst;
   end

   // Entry written into the FIFO: data, optionally prefixed by source tag.
   always_comb begin
      sel_data = input_in[32'(grant_idx) * WIDTH +: WIDTH];
`ifdef STREAM_HUB_TAG_EN
      wr_entry = {grant_idx, sel_data};
`else
      wr_entry = sel_data;
`endif
   end

   // Head presentation; reads zero while empty so stale storage never leaks out.
   always_comb begin
      head_entry = mem[rd_ptr];
      output_out = not_empty ? head_entry[WIDTH-1:0] : '0;
`ifdef STREAM_HUB_TAG_EN
      output_out_tag = not_empty ? head_entry[ENTRY_W-1 -: SRC_W] : '0;
`endif
   end

   // FIFO storage (no reset needed; occupancy is tracked by count).
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_entry;
      end
   end

   // Pointers, occupancy and arbitration history.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         last_grant <= SRC_W'(CHANNELS - 1);
      end else begin
         if (push) begin
            wr_ptr     <= wr_ptr + PTR_W'(1);
            last_grant <= grant_idx;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Lowest asserted exception index.
   always_comb begin
      exc_found = 1'b0;
      exc_idx   = '0;
      exc_i     = 0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         exc_i = i;
         if (!exc_found && exception_in[SRC_W'(exc_i)]) begin
            exc_found = 1'b1;
            exc_idx   = SRC_W'(exc_i);
         end
      end
   end

   // Sticky exception; source captured only on the first flagged edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         exception     <= 1'b0;
         exception_src <= '0;
      end else if (!exception && exc_found) begin
         exception     <= 1'b1;
         exception_src <= exc_idx;
      end
   end

endmodule

// File: tb/tb_stream_hub.sv
// tb_stream_hub: directed stimulus for stream_hub with a behavioural model and
// an in-order scoreboard of accepted words.

module tb_stream_hub;

   localparam int unsigned CH = 4;
   localparam int unsigned W  = 32;
   localparam int unsigned D  = 4;

   typedef struct {
      logic [W-1:0] data;
      logic [1:0]   tag;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic [CH*W-1:0] input_in;
   logic [CH-1:0]   stb;
   logic [CH-1:0]   ack;
   logic [W-1:0]    out;
   logic            out_stb;
   logic            out_ack;
   logic [CH-1:0]   exc_in;
   logic            exc;
   logic [1:0]      exc_src;
`ifdef STREAM_HUB_TAG_EN
   logic [1:0]      out_tag;
`endif

   logic [W-1:0]    d [CH];

   exp_t            sb [$];
   int              m_cnt;
   int              m_lg;
   logic            m_exc;
   logic [1:0]      m_src;
   int              pushed_ch;
   int              checks;
   int              passes;
   int              fails;
   int              n;

   always #5 clk = ~clk;

   always_comb input_in = {d[3], d[2], d[1], d[0]};

   stream_hub #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D)) dut (
      .clk            (clk),
      .rst            (rst),
      .input_in       (input_in),
      .input_in_stb   (stb),
      .input_in_ack   (ack),
      .output_out     (out),
      .output_out_stb (out_stb),
      .output_out_ack (out_ack),
      .exception_in   (exc_in),
      .exception      (exc),
      .exception_src  (exc_src)
`ifdef STREAM_HUB_TAG_EN
      ,
      .output_out_tag (out_tag)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock: check combinational outputs against the model before the edge,
   // advance the model across the edge, then check registered outputs.
   task automatic tick();
      int         gch;
      int         c;
      logic [3:0] exp_ack;
      logic       pop;
      exp_t       e;
      #1;
      gch = -1;
      if (!rst && m_cnt < int'(D)) begin
         for (int i = 1; i <= int'(CH); i++) begin
            c = (m_lg + i) % int'(CH);
            if (gch < 0 && stb[c]) gch = c;
         end
      end
      exp_ack = (gch >= 0) ? 4'(1 << gch) : 4'b0000;
      chk("in_ack", 64'(ack), 64'(exp_ack));
      chk("out_stb", 64'(out_stb), 64'(!rst && m_cnt > 0));
      pop = !rst && (m_cnt > 0) && out_ack;
      if (pop) begin
         if (sb.size() == 0) begin
            chk("scoreboard_underflow", 64'(0), 64'(1));
         end else begin
            e = sb.pop_front();
            chk("out_data", 64'(out), 64'(e.data));
`ifdef STREAM_HUB_TAG_EN
            chk("out_tag", 64'(out_tag), 64'(e.tag));
`endif
         end
      end
      pushed_ch = gch;
      if (rst) begin
         sb.delete();
         m_cnt = 0;
         m_lg  = int'(CH) - 1;
         m_exc = 1'b0;
         m_src = 2'd0;
      end else begin
         if (gch >= 0) begin
            e.data = d[gch];
            e.tag  = 2'(gch);
            sb.push_back(e);
            m_lg  = gch;
            m_cnt = m_cnt + 1;
         end
         if (pop) m_cnt = m_cnt - 1;
         if (!m_exc && exc_in != '0) begin
            m_exc = 1'b1;
            for (int i = int'(CH) - 1; i >= 0; i--) begin
               if (exc_in[i]) m_src = 2'(i);
            end
         end
      end
      @(posedge clk);
      #1;
      chk("exception", 64'(exc), 64'(m_exc));
      chk("exception_src", 64'(exc_src), 64'(m_src));
   endtask

   initial begin
      rst     = 1'b1;
      stb     = '0;
      out_ack = 1'b0;
      exc_in  = '0;
      for (int k = 0; k < int'(CH); k++) d[k] = '0;
      m_cnt     = 0;
      m_lg      = int'(CH) - 1;
      m_exc     = 1'b0;
      m_src     = 2'd0;
      pushed_ch = -1;
      checks    = 0;
      passes    = 0;
      fails     = 0;
      n         = 0;

      // Reset state
      tick();
      tick();
      rst = 1'b0;
      chk("out_after_reset", 64'(out), 64'(0));
      chk("stb_after_reset", 64'(out_stb), 64'(0));

      // All channels streaming, sink always ready: round-robin order
      for (int k = 0; k < int'(CH); k++) d[k] = 32'h10 + 32'(k);
      stb     = '1;
      out_ack = 1'b1;
      repeat (12) tick();
      stb = '0;
      repeat (3) tick();

      // Backpressure: channel 2 fills the FIFO, then drains in order
      out_ack = 1'b0;
      n       = 0;
      d[2]    = 32'hA0;
      stb     = 4'b0100;
      repeat (6) begin
         tick();
         if (pushed_ch == 2) begin n++; d[2] = 32'hA0 + 32'(n); end
      end
      chk("words_before_full", 64'(n), 64'(4));
      #1;
      chk("ack_zero_when_full", 64'(ack), 64'(0));
      out_ack = 1'b1;
      for (int t = 0; t < 20 && n < 6; t++) begin
         tick();
         if (pushed_ch == 2) begin n++; d[2] = 32'hA0 + 32'(n); end
      end
      chk("all_words_sent", 64'(n), 64'(6));
      stb = '0;
      repeat (6) tick();

      // Full FIFO: simultaneous pop and strobe must not push that cycle
      out_ack = 1'b0;
      n       = 0;
      d[1]    = 32'hB0;
      stb     = 4'b0010;
      repeat (5) begin
         tick();
         if (pushed_ch == 1) begin n++; d[1] = 32'hB0 + 32'(n); end
      end
      out_ack = 1'b1;
      #1;
      chk("ack_blocked_full_pop", 64'(ack), 64'(0));
      tick();
      out_ack = 1'b0;
      #1;
      chk("ack_after_pop", 64'(ack), 64'(4'b0010));
      tick();
      stb     = '0;
      out_ack = 1'b1;
      repeat (6) tick();

      // Exceptions while streaming continues on channel 0
      d[0]    = 32'hC0;
      stb     = 4'b0001;
      exc_in  = 4'b1010;
      tick();
      chk("exception_set", 64'(exc), 64'(1));
      exc_in = '0;
      repeat (2) tick();
      exc_in = 4'b0001;
      tick();
      exc_in = '0;
      tick();
      chk("exception_src_sticky", 64'(exc_src), 64'(1));
      stb = '0;
      repeat (3) tick();

      // Reset with three words queued
      out_ack = 1'b0;
      d[2]    = 32'hD0;
      stb     = 4'b0100;
      repeat (3) tick();
      stb = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("stb_low_after_midreset", 64'(out_stb), 64'(0));
      chk("exc_low_after_midreset", 64'(exc), 64'(0));
      stb = '1;
      #1;
      chk("grant_ch0_after_reset", 64'(ack), 64'(4'b0001));
      tick();
      stb     = '0;
      out_ack = 1'b1;
      repeat (3) tick();

      // Single word on channel 3 into an empty FIFO
      out_ack = 1'b0;
      d[3]    = 32'hE3;
      stb     = 4'b1000;
      tick();
      stb = '0;
      chk("single_stb_high", 64'(out_stb), 64'(1));
      chk("single_data", 64'(out), 64'(32'hE3));
      out_ack = 1'b1;
      tick();
      out_ack = 1'b0;
      chk("single_stb_low", 64'(out_stb), 64'(0));
      tick();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/stream_hub.md
STREAM_HUB -- requirements
Module: stream_hub

Interface
REQ-001 SHALL provide parameter CHANNELS, default 4, number of input streams (2..16).
REQ-002 SHALL provide parameter WIDTH, default 32, data width per stream.
REQ-003 SHALL provide parameter DEPTH, default 4, output FIFO depth in words (power of two, >=2).
REQ-004 SHALL provide port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL provide port input_in  input  CHANNELS*WIDTH  channel k data in bits [k*WIDTH +: WIDTH].
REQ-007 SHALL provide port input_in_stb  input  CHANNELS  per-channel data-valid strobe.
REQ-008 SHALL provide port input_in_ack  output  CHANNELS  per-channel acknowledge; transfer when stb and ack both high at clock edge.
REQ-009 SHALL provide port output_out  output  WIDTH  FIFO head data.
REQ-010 SHALL provide port output_out_stb  output  1  FIFO non-empty.
REQ-011 SHALL provide port output_out_ack  input  1  sink acknowledge; pop when stb and ack both high.
REQ-012 SHALL provide port exception_in  input  CHANNELS  per-process exception flags.
REQ-013 SHALL provide port exception  output  1  sticky aggregated exception.
REQ-014 SHALL provide port exception_src  output  clog2(CHANNELS)  index of first-offending channel.

Function
REQ-015 SHALL accept at most one input word per cycle.
REQ-016 SHALL grant, when FIFO count < DEPTH, the first channel with stb high searching from (last_grant+1) mod CHANNELS upward with wrap-around.
REQ-017 SHALL drive input_in_ack combinationally: high only for the granted channel, all zero when FIFO full or no stb high.
REQ-018 SHALL update last_grant to the granted index only on an accepted transfer.
REQ-019 SHALL block push whenever count == DEPTH, even if a pop occurs the same cycle.
REQ-020 SHALL, on simultaneous push and pop with 0 < count < DEPTH, keep count unchanged and preserve order.
REQ-021 SHALL present a word accepted at edge N on output_out with output_out_stb high from cycle N+1 when FIFO was empty (latency 1).
REQ-022 SHALL hold output_out stable while output_out_stb high and output_out_ack low.
REQ-023 SHALL wrap read/write pointers modulo DEPTH; count width clog2(DEPTH+1).
REQ-024 SHALL set exception on the first edge where any exception_in bit is high and hold it until reset.
REQ-025 SHALL load exception_src with the lowest asserted exception_in index on that edge only; later exceptions SHALL NOT change it.
REQ-026 SHALL continue streaming normally while exception is set.

Reset
REQ-027 SHALL, on rst high at clock edge, clear count, pointers, exception (0), exception_src (0), and set last_grant to CHANNELS-1 so channel 0 has first priority.
REQ-028 SHALL hold output_out_stb and input_in_ack low during reset; output_out SHALL read 0 after reset.
REQ-029 SHALL discard FIFO contents on reset mid-operation; no word accepted in the reset cycle.

Configuration
REQ-030 SHALL, when STREAM_HUB_TAG_EN is defined, add output port output_out_tag (clog2(CHANNELS) bits) carrying the source channel index stored with each word, aligned with output_out, reset value 0.
REQ-031 SHALL, when STREAM_HUB_TAG_EN is undefined, omit output_out_tag and store WIDTH bits per FIFO entry only.

Verification
REQ-032 SHALL cover: all 4 channels stb high continuously with data 0x10..0x13, sink ack high -> output order 0x10,0x11,0x12,0x13,0x10,...; tag 0,1,2,3 when STREAM_HUB_TAG_EN.
REQ-033 SHALL cover: sink ack low, channel 2 streams 0xA0..0xA5 -> acks for 4 words then input_in_ack all zero; after ack high, 0xA0..0xA3 out in order then 0xA4,0xA5.
REQ-034 SHALL cover: FIFO full, sink pops and channel 1 strobes same cycle -> no push that cycle, count 3, push accepted next cycle.
REQ-035 SHALL cover: exception_in = 4'b1010 at cycle 5, 4'b0001 at cycle 8 -> exception high from cycle 6, exception_src = 1 permanently.
REQ-036 SHALL cover: rst pulsed with 3 words queued -> output_out_stb low next cycle, count 0, exception 0, next grant channel 0.
REQ-037 SHALL cover: single word on channel 3 into empty FIFO at edge N -> output_out_stb high at N+1, low after one ack.
